mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  Memory-access pipeline stage. Sits directly upstream of the write-back stage and feeds its
//  aluResult1 / Data_input1 / writeRegister1 / MemtoReg1 / do_writeback1 inputs.
//  Issues loads/stores to the data memory over a req/ack handshake with variable latency.
//  Stalls the upstream pipeline while an access is outstanding. Non-memory ops pass through with 1-cycle latency.
// PARAMETERS
//  AW  32  data-memory address width (dmem_addr = aluResult1[AW-1:0])
// PORTS
//  CLK             in   1   clock, all state on posedge
//  RESET           in   1   synchronous, active-high reset
//  in_valid        in   1   upstream op valid this cycle
//  MemRead1        in   1   op is a load
//  MemWrite1       in   1   op is a store (wins if MemRead1 also set)
//  aluResult1      in   32  effective address / ALU result
//  storeData1      in   32  store data (rt value)
//  writeRegister1  in   5   destination register
//  MemtoReg1       in   1   WB selects memory data
//  do_writeback1   in   1   op writes the register file
//  mem_size1       in   2   00 byte, 01 half, 10 word (used only with MEM_SUBWORD_EN)
//  load_unsigned1  in   1   zero-extend sub-word loads (used only with MEM_SUBWORD_EN)
//  stall_OUT       out  1   upstream must hold its outputs; in_valid is ignored while 1
//  dmem_req        out  1   memory request, registered
//  dmem_we         out  1   1 = write
//  dmem_addr       out  AW  request address
//  dmem_wdata      out  32  write data
//  dmem_be         out  4   byte enables
//  dmem_rdata      in   32  read data, valid with dmem_ack
//  dmem_ack        in   1   single-cycle completion pulse
//  aluResult1_OUT, Data_input1_OUT  out 32; writeRegister1_OUT out 5; MemtoReg1_OUT, do_writeback1_OUT out 1
// BEHAVIOUR
//  - Reset: state=IDLE; all outputs 0, including dmem_req, stall_OUT, do_writeback1_OUT.
//  - FSM states: IDLE, BUSY.
//  - IDLE, in_valid, not a memory op: next cycle, outputs = inputs, Data_input1_OUT=0, do_writeback1_OUT=do_writeback1.
//  - IDLE, in_valid and (MemRead1|MemWrite1): capture op into hold regs; next cycle dmem_req=1 with
//    addr/we/wdata/be; state->BUSY; do_writeback1_OUT=0 (bubble).
//  - IDLE, !in_valid: do_writeback1_OUT=0; other outputs hold.
//  - BUSY: stall_OUT=1 (combinational from state); dmem_req and its fields held stable until dmem_ack.
//    do_writeback1_OUT=0 each BUSY cycle without ack.
//  - BUSY & dmem_ack: dmem_req->0 next cycle; WB outputs loaded from hold regs; Data_input1_OUT = load
//    data (stores: 0); do_writeback1_OUT = held do_writeback1 for exactly 1 cycle; state->IDLE.
//  - Minimum memory-op latency: 2 cycles from accept to WB-output valid (ack in first req cycle).
//  - dmem_ack while IDLE: ignored.
//  - Word access: dmem_addr[1:0] forced to 00; dmem_be=4'hF.
//  - RESET while BUSY: req dropped next cycle, no writeback issued, the access is abandoned.
// CONFIGURATION
//  MEM_SUBWORD_EN defined:
//    - byte/half stores replicate data across lanes; dmem_be = 0001<<addr[1:0] or 0011<<{addr[1],0}.
//    - Loads select the lane and sign-extend, or zero-extend if load_unsigned1.
//    - Half access at addr[0]=1 is treated as addr[0]=0.
//  MEM_SUBWORD_EN undefined:
//    - mem_size1 and load_unsigned1 are ignored; every access is a word access.
//    - dmem_be=4'hF; Data_input1_OUT = dmem_rdata.
// TESTING
//  1. RESET=1 for 2 cycles -> all outputs 0; ALU op (alu=0x10, rd=5, wb=1)
//     -> next cycle aluResult1_OUT=0x10, writeRegister1_OUT=5, do_writeback1_OUT=1.
//  2. Load addr 0x100, ack 3 cycles after req -> stall_OUT high 4 cycles; dmem_req held;
//     Data_input1_OUT=rdata 0xDEADBEEF; do_writeback1_OUT pulses once.
//  3. Store addr 0x207, data 0x12345678, ack in first cycle
//     -> dmem_addr=0x204, we=1, be=F; do_writeback1_OUT stays 0.
//  4. RESET asserted in 2nd BUSY cycle -> dmem_req=0, stall_OUT=0 next cycle; no writeback;
//     a later ALU op passes normally.
//  5. MEM_SUBWORD_EN: lb at 0x103, rdata 0x80FFFFFF -> Data_input1_OUT=0xFFFFFF80, be=1000;
//     lbu -> 0x00000080.
//  6. Spurious dmem_ack in IDLE, and in_valid while stall_OUT=1 -> both ignored; no output change.

Source files
------------

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage -- memory-access pipeline stage
//
// Sits between execute and write-back. ALU-only ops pass through with one
// cycle of latency. Loads and stores are captured into hold registers and
// issued to the data memory over a req/ack handshake. The handshake may take
// any number of cycles; the upstream pipeline is stalled while it is open.
// The write-back outputs are produced when the access completes.
//
// Optional feature macro: MEM_SUBWORD_EN
//   defined   : byte/half accesses (lane-replicated stores, per-lane byte
//               enables, sign/zero-extended loads)
//   undefined : every access is a 32-bit word access; mem_size1 and
//               load_unsigned1 are ignored
//
// Parameters
//   AW                  data-memory address width
//
// Ports
//   CLK                 clock, all state on posedge
//   RESET               synchronous, active-high reset
//   in_valid            upstream op valid (ignored while stall_OUT=1)
//   MemRead1/MemWrite1  load / store (store wins when both are set)
//   aluResult1          effective address or ALU result
//   storeData1          store data
//   writeRegister1      destination register
//   MemtoReg1           write-back selects memory data
//   do_writeback1       op writes the register file
//   mem_size1           00 byte, 01 half, 10 word (MEM_SUBWORD_EN only)
//   load_unsigned1      zero-extend sub-word loads (MEM_SUBWORD_EN only)
//   stall_OUT           upstream must hold; high for every BUSY cycle
//   dmem_req/we/addr/wdata/be   registered memory request, stable until ack
//   dmem_rdata/dmem_ack read data and single-cycle completion pulse
//   aluResult1_OUT, Data_input1_OUT, writeRegister1_OUT, MemtoReg1_OUT,
//   do_writeback1_OUT   registered outputs to the write-back stage
// -----------------------------------------------------------------------------
module mem_stage #(
    parameter int AW = 32
) (
    input  logic          CLK,
    input  logic          RESET,

    input  logic          in_valid,
    input  logic          MemRead1,
    input  logic          MemWrite1,
    input  logic [31:0]   aluResult1,
    input  logic [31:0]   storeData1,
    input  logic [4:0]    writeRegister1,
    input  logic          MemtoReg1,
    input  logic          do_writeback1,
    input  logic [1:0]    mem_size1,
    input  logic          load_unsigned1,

    output logic          stall_OUT,

    output logic          dmem_req,
    output logic          dmem_we,
    output logic [AW-1:0] dmem_addr,
    output logic [31:0]   dmem_wdata,
    output logic [3:0]    dmem_be,
    input  logic [31:0]   dmem_rdata,
    input  logic          dmem_ack,

    output logic [31:0]   aluResult1_OUT,
    output logic [31:0]   Data_input1_OUT,
    output logic [4:0]    writeRegister1_OUT,
    output logic          MemtoReg1_OUT,
    output logic          do_writeback1_OUT
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;

    state_t state, state_n;

    // Next-value copies of every register.
    logic          req_n;
    logic          we_n;
    logic [AW-1:0] addr_n;
    logic [31:0]   wdata_n;
    logic [3:0]    be_n;
    logic [31:0]   alu_out_n;
    logic [31:0]   data_out_n;
    logic [4:0]    wreg_out_n;
    logic          mtr_out_n;
    logic          wb_out_n;

    // Hold registers: the accepted memory op's write-back fields.
    logic [31:0]   hold_alu,   hold_alu_n;
    logic [4:0]    hold_wreg,  hold_wreg_n;
    logic          hold_mtr,   hold_mtr_n;
    logic          hold_wb,    hold_wb_n;
    logic          hold_store, hold_store_n;

    // Request fields formatted from the current inputs, and load data
    // formatted from the returning read data.
    logic [AW-1:0] fmt_addr;
    logic [31:0]   fmt_wdata;
    logic [3:0]    fmt_be;
    logic [31:0]   load_data;

    logic          is_mem_op;

    assign is_mem_op = MemRead1 | MemWrite1;
    assign stall_OUT = (state == BUSY);

`ifdef MEM_SUBWORD_EN
    // Sub-word access needs the size, signedness and byte offset after the
    // inputs have moved on, to pick the lane out of the read data.
    logic [1:0]    hold_size,  hold_size_n;
    logic          hold_uns,   hold_uns_n;
    logic [1:0]    hold_off,   hold_off_n;

    always_comb begin
        fmt_addr  = {aluResult1[AW-1:2], 2'b00};
        fmt_wdata = storeData1;
        fmt_be    = 4'hF;
        case (mem_size1)
            SIZE_BYTE: begin
                fmt_addr  = aluResult1[AW-1:0];
                fmt_wdata = {4{storeData1[7:0]}};
                fmt_be    = 4'b0001 << aluResult1[1:0];
            end
            SIZE_HALF: begin
                // An odd half-word address is treated as the even one.
                fmt_addr  = {aluResult1[AW-1:1], 1'b0};
                fmt_wdata = {2{storeData1[15:0]}};
                fmt_be    = 4'b0011 << {aluResult1[1], 1'b0};
            end
            default: ;
        endcase
    end

    always_comb begin
        logic [7:0]  lane_b;
        logic [15:0] lane_h;
        lane_b    = dmem_rdata[7:0];
        lane_h    = hold_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        load_data = dmem_rdata;
        case (hold_off)
            2'd0:    lane_b = dmem_rdata[7:0];
            2'd1:    lane_b = dmem_rdata[15:8];
            2'd2:    lane_b = dmem_rdata[23:16];
            default: lane_b = dmem_rdata[31:24];
        endcase
        case (hold_size)
            SIZE_BYTE: load_data = hold_uns ? {24'h0, lane_b}
                                            : {{24{lane_b[7]}}, lane_b};
            SIZE_HALF: load_data = hold_uns ? {16'h0, lane_h}
                                            : {{16{lane_h[15]}}, lane_h};
            default:   load_data = dmem_rdata;
        endcase
    end
`else
    // Word-only build: sub-word controls have no effect.
    logic unused_subword;
    assign unused_subword = ^{mem_size1, load_unsigned1};

    assign fmt_addr  = {aluResult1[AW-1:2], 2'b00};
    assign fmt_wdata = storeData1;
    assign fmt_be    = 4'hF;
    assign load_data = dmem_rdata;
`endif

    // Next-state and next-output logic.
    // NOTE: every signal gets a default at the top of the block so that no
    // path leaves it unassigned; a missing default infers a latch.
    always_comb begin
        state_n      = state;
        req_n        = dmem_req;
        we_n         = dmem_we;
        addr_n       = dmem_addr;
        wdata_n      = dmem_wdata;
        be_n         = dmem_be;
        alu_out_n    = aluResult1_OUT;
        data_out_n   = Data_input1_OUT;
        wreg_out_n   = writeRegister1_OUT;
        mtr_out_n    = MemtoReg1_OUT;
        wb_out_n     = 1'b0;           // write-back is a single-cycle pulse
        hold_alu_n   = hold_alu;
        hold_wreg_n  = hold_wreg;
        hold_mtr_n   = hold_mtr;
        hold_wb_n    = hold_wb;
        hold_store_n = hold_store;
`ifdef MEM_SUBWORD_EN
        hold_size_n  = hold_size;
        hold_uns_n   = hold_uns;
        hold_off_n   = hold_off;
`endif

        case (state)
            IDLE: begin
                // dmem_ack is deliberately not looked at here.
                if (in_valid) begin
                    if (is_mem_op) begin
                        hold_alu_n   = aluResult1;
                        hold_wreg_n  = writeRegister1;
                        hold_mtr_n   = MemtoReg1;
                        hold_wb_n    = do_writeback1;
                        hold_store_n = MemWrite1;
`ifdef MEM_SUBWORD_EN
                        hold_size_n  = mem_size1;
                        hold_uns_n   = load_unsigned1;
                        hold_off_n   = aluResult1[1:0];
`endif
                        req_n        = 1'b1;
                        we_n         = MemWrite1;
                        addr_n       = fmt_addr;
                        wdata_n      = fmt_wdata;
                        be_n         = fmt_be;
                        state_n      = BUSY;
                    end else begin
                        alu_out_n    = aluResult1;
                        data_out_n   = 32'h0;
                        wreg_out_n   = writeRegister1;
                        mtr_out_n    = MemtoReg1;
                        wb_out_n     = do_writeback1;
                    end
                end
            end

            BUSY: begin
                if (dmem_ack) begin
                    req_n      = 1'b0;
                    alu_out_n  = hold_alu;
                    data_out_n = hold_store ? 32'h0 : load_data;
                    wreg_out_n = hold_wreg;
                    mtr_out_n  = hold_mtr;
                    wb_out_n   = hold_wb;
                    state_n    = IDLE;
                end
            end

            default: state_n = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before this edge.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            // NOTE: the hold registers are cleared too; they are a handful of
            // flops, and clearing them keeps post-reset outputs deterministic.
            state              <= IDLE;
            dmem_req           <= 1'b0;
            dmem_we            <= 1'b0;
            dmem_addr          <= '0;
            dmem_wdata         <= 32'h0;
            dmem_be            <= 4'h0;
            aluResult1_OUT     <= 32'h0;
            Data_input1_OUT    <= 32'h0;
            writeRegister1_OUT <= 5'h0;
            MemtoReg1_OUT      <= 1'b0;
            do_writeback1_OUT  <= 1'b0;
            hold_alu           <= 32'h0;
            hold_wreg          <= 5'h0;
            hold_mtr           <= 1'b0;
            hold_wb            <= 1'b0;
            hold_store         <= 1'b0;
`ifdef MEM_SUBWORD_EN
            hold_size          <= 2'b00;
            hold_uns           <= 1'b0;
            hold_off           <= 2'b00;
`endif
        end else begin
            state              <= state_n;
            dmem_req           <= req_n;
            dmem_we            <= we_n;
            dmem_addr          <= addr_n;
            dmem_wdata         <= wdata_n;
            dmem_be            <= be_n;
            aluResult1_OUT     <= alu_out_n;
            Data_input1_OUT    <= data_out_n;
            writeRegister1_OUT <= wreg_out_n;
            MemtoReg1_OUT      <= mtr_out_n;
            do_writeback1_OUT  <= wb_out_n;
            hold_alu           <= hold_alu_n;
            hold_wreg          <= hold_wreg_n;
            hold_mtr           <= hold_mtr_n;
            hold_wb            <= hold_wb_n;
            hold_store         <= hold_store_n;
`ifdef MEM_SUBWORD_EN
            hold_size          <= hold_size_n;
            hold_uns           <= hold_uns_n;
            hold_off           <= hold_off_n;
`endif
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage -- scoreboard bench for mem_stage
//
// Stimulus tasks push the expected memory request and expected write-back
// record into queues; a monitor on the falling edge pops and compares
// whenever the DUT raises dmem_req or pulses do_writeback1_OUT. Inputs are
// driven and outputs sampled on the falling edge (all DUT outputs are
// registered or state-derived).
// -----------------------------------------------------------------------------
module tb_mem_stage;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        in_valid;
    logic        MemRead1;
    logic        MemWrite1;
    logic [31:0] aluResult1;
    logic [31:0] storeData1;
    logic [4:0]  writeRegister1;
    logic        MemtoReg1;
    logic        do_writeback1;
    logic [1:0]  mem_size1;
    logic        load_unsigned1;
    logic        stall_OUT;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;
    logic [31:0] aluResult1_OUT;
    logic [31:0] Data_input1_OUT;
    logic [4:0]  writeRegister1_OUT;
    logic        MemtoReg1_OUT;
    logic        do_writeback1_OUT;

    always #5 CLK = ~CLK;

    mem_stage #(.AW(32)) dut (
        .CLK                (CLK),
        .RESET              (RESET),
        .in_valid           (in_valid),
        .MemRead1           (MemRead1),
        .MemWrite1          (MemWrite1),
        .aluResult1         (aluResult1),
        .storeData1         (storeData1),
        .writeRegister1     (writeRegister1),
        .MemtoReg1          (MemtoReg1),
        .do_writeback1      (do_writeback1),
        .mem_size1          (mem_size1),
        .load_unsigned1     (load_unsigned1),
        .stall_OUT          (stall_OUT),
        .dmem_req           (dmem_req),
        .dmem_we            (dmem_we),
        .dmem_addr          (dmem_addr),
        .dmem_wdata         (dmem_wdata),
        .dmem_be            (dmem_be),
        .dmem_rdata         (dmem_rdata),
        .dmem_ack           (dmem_ack),
        .aluResult1_OUT     (aluResult1_OUT),
        .Data_input1_OUT    (Data_input1_OUT),
        .writeRegister1_OUT (writeRegister1_OUT),
        .MemtoReg1_OUT      (MemtoReg1_OUT),
        .do_writeback1_OUT  (do_writeback1_OUT)
    );

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] data;
        logic [4:0]  wreg;
        logic        mtr;
    } wb_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } req_t;

    wb_t  wb_q[$];
    req_t req_q[$];
    wb_t  exp_wb;
    req_t exp_req;
    logic prev_req = 1'b0;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: DUT output with no expected entry", name);
    endtask

    // ---------------- monitor ----------------
    always @(negedge CLK) begin
        if (do_writeback1_OUT) begin
            if (wb_q.size() == 0) begin
                fail("wb_unexpected");
            end else begin
                exp_wb = wb_q.pop_front();
                check("wb_alu",  aluResult1_OUT,              exp_wb.alu);
                check("wb_data", Data_input1_OUT,             exp_wb.data);
                check("wb_wreg", 32'(writeRegister1_OUT),     32'(exp_wb.wreg));
                check("wb_mtr",  32'(MemtoReg1_OUT),          32'(exp_wb.mtr));
            end
        end
        if (dmem_req && !prev_req) begin
            if (req_q.size() == 0) begin
                fail("req_unexpected");
            end else begin
                exp_req = req_q.pop_front();
                check("req_we",    32'(dmem_we), 32'(exp_req.we));
                check("req_addr",  dmem_addr,    exp_req.addr);
                check("req_wdata", dmem_wdata,   exp_req.wdata);
                check("req_be",    32'(dmem_be), 32'(exp_req.be));
            end
        end
        prev_req = dmem_req;
    end

    // ---------------- stimulus helpers ----------------
    task automatic clear_inputs();
        in_valid       = 1'b0;
        MemRead1       = 1'b0;
        MemWrite1      = 1'b0;
        aluResult1     = 32'h0;
        storeData1     = 32'h0;
        writeRegister1 = 5'h0;
        MemtoReg1      = 1'b0;
        do_writeback1  = 1'b0;
        mem_size1      = 2'b10;
        load_unsigned1 = 1'b0;
    endtask

    task automatic alu_op(input logic [31:0] alu, input logic [4:0] rd,
                          input logic mtr, input logic wb);
        @(negedge CLK);
        clear_inputs();
        in_valid       = 1'b1;
        aluResult1     = alu;
        writeRegister1 = rd;
        MemtoReg1      = mtr;
        do_writeback1  = wb;
        if (wb) wb_q.push_back('{alu, 32'h0, rd, mtr});
        @(negedge CLK);
        clear_inputs();
    endtask

    // One load or store, acked `delay` cycles after the first request cycle.
    task automatic mem_op(input string tag, input logic wr, input logic [31:0] alu,
                          input logic [31:0] sd, input logic [4:0] rd, input logic wb,
                          input logic [1:0] sz, input logic uns, input int delay,
                          input logic [31:0] rdata, input logic [31:0] exp_data,
                          input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                          input logic [3:0] exp_be);
        int stalls;
        @(negedge CLK);
        clear_inputs();
        in_valid       = 1'b1;
        MemRead1       = ~wr;
        MemWrite1      = wr;
        aluResult1     = alu;
        storeData1     = sd;
        writeRegister1 = rd;
        MemtoReg1      = ~wr;
        do_writeback1  = wb;
        mem_size1      = sz;
        load_unsigned1 = uns;
        req_q.push_back('{wr, exp_addr, exp_wdata, exp_be});
        if (wb) wb_q.push_back('{alu, (wr ? 32'h0 : exp_data), rd, ~wr});
        @(negedge CLK);
        clear_inputs();
        stalls = 0;
        for (int k = 0; k <= delay; k++) begin
            if (stall_OUT) stalls++;
            check({tag, "_req_held"},  32'(dmem_req), 32'd1);
            check({tag, "_addr_held"}, dmem_addr,     exp_addr);
            if (k == delay) begin
                dmem_ack   = 1'b1;
                dmem_rdata = rdata;
            end
            @(negedge CLK);
            dmem_ack   = 1'b0;
            dmem_rdata = 32'hA5A5_A5A5;
        end
        check({tag, "_stall_cycles"}, 32'(stalls),    32'(delay + 1));
        check({tag, "_stall_after"},  32'(stall_OUT), 32'd0);
        check({tag, "_req_after"},    32'(dmem_req),  32'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        clear_inputs();
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        RESET      = 1'b1;

        // 1. reset state, then a plain ALU op
        @(negedge CLK);
        @(negedge CLK);
        check("rst_stall", 32'(stall_OUT),          32'd0);
        check("rst_req",   32'(dmem_req),           32'd0);
        check("rst_we",    32'(dmem_we),            32'd0);
        check("rst_addr",  dmem_addr,               32'h0);
        check("rst_be",    32'(dmem_be),            32'd0);
        check("rst_alu",   aluResult1_OUT,          32'h0);
        check("rst_data",  Data_input1_OUT,         32'h0);
        check("rst_wreg",  32'(writeRegister1_OUT), 32'd0);
        check("rst_wb",    32'(do_writeback1_OUT),  32'd0);
        RESET = 1'b0;
        alu_op(32'h10, 5'd5, 1'b0, 1'b1);
        alu_op(32'h77, 5'd6, 1'b0, 1'b0);   // no register write: no pulse

        // 2. word load, ack three cycles after the first request cycle
        mem_op("ld", 1'b0, 32'h100, 32'h0, 5'd8, 1'b1, 2'b10, 1'b0, 3,
               32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h100, 32'h0, 4'hF);

        // 3. unaligned word store, ack in first request cycle
        mem_op("st", 1'b1, 32'h207, 32'h1234_5678, 5'd0, 1'b0, 2'b10, 1'b0, 0,
               32'h0, 32'h0, 32'h204, 32'h1234_5678, 4'hF);

        // 4. reset during the second BUSY cycle abandons the load
        @(negedge CLK);
        clear_inputs();
        in_valid       = 1'b1;
        MemRead1       = 1'b1;
        aluResult1     = 32'h300;
        writeRegister1 = 5'd12;
        MemtoReg1      = 1'b1;
        do_writeback1  = 1'b1;
        req_q.push_back('{1'b0, 32'h300, 32'h0, 4'hF});
        @(negedge CLK);
        clear_inputs();
        check("rb_stall_busy", 32'(stall_OUT), 32'd1);
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        check("rb_req",   32'(dmem_req),  32'd0);
        check("rb_stall", 32'(stall_OUT), 32'd0);
        check("rb_alu",   aluResult1_OUT, 32'h0);
        alu_op(32'h33, 5'd31, 1'b0, 1'b1);

        // 6a. spurious ack while idle changes nothing
        @(negedge CLK);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hFFFF_FFFF;
        @(negedge CLK);
        dmem_ack   = 1'b0;
        check("sp_req",   32'(dmem_req),           32'd0);
        check("sp_stall", 32'(stall_OUT),          32'd0);
        check("sp_alu",   aluResult1_OUT,          32'h33);
        check("sp_data",  Data_input1_OUT,         32'h0);
        check("sp_wreg",  32'(writeRegister1_OUT), 32'd31);

        // 6b. in_valid while stalled is ignored
        @(negedge CLK);
        clear_inputs();
        in_valid       = 1'b1;
        MemRead1       = 1'b1;
        aluResult1     = 32'h400;
        writeRegister1 = 5'd9;
        MemtoReg1      = 1'b1;
        do_writeback1  = 1'b1;
        req_q.push_back('{1'b0, 32'h400, 32'h0, 4'hF});
        wb_q.push_back('{32'h400, 32'h0BAD_F00D, 5'd9, 1'b1});
        @(negedge CLK);
        clear_inputs();
        in_valid       = 1'b1;              // ALU op offered during stall
        aluResult1     = 32'h55;
        writeRegister1 = 5'd3;
        do_writeback1  = 1'b1;
        @(negedge CLK);
        clear_inputs();
        @(negedge CLK);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h0BAD_F00D;
        @(negedge CLK);
        dmem_ack   = 1'b0;
        check("ig_stall", 32'(stall_OUT), 32'd0);

        // 5. sub-word accesses (word-only build treats them as words)
`ifdef MEM_SUBWORD_EN
        mem_op("lb",  1'b0, 32'h103, 32'h0, 5'd10, 1'b1, 2'b00, 1'b0, 1,
               32'h80FF_FFFF, 32'hFFFF_FF80, 32'h103, 32'h0, 4'b1000);
        mem_op("lbu", 1'b0, 32'h103, 32'h0, 5'd11, 1'b1, 2'b00, 1'b1, 0,
               32'h80FF_FFFF, 32'h0000_0080, 32'h103, 32'h0, 4'b1000);
        mem_op("lh",  1'b0, 32'h102, 32'h0, 5'd13, 1'b1, 2'b01, 1'b0, 0,
               32'h8001_1234, 32'hFFFF_8001, 32'h102, 32'h0, 4'b1100);
        mem_op("sh",  1'b1, 32'h206, 32'h0000_ABCD, 5'd0, 1'b0, 2'b01, 1'b0, 1,
               32'h0, 32'h0, 32'h206, 32'hABCD_ABCD, 4'b1100);
`else
        mem_op("lb",  1'b0, 32'h103, 32'h0, 5'd10, 1'b1, 2'b00, 1'b0, 1,
               32'h80FF_FFFF, 32'h80FF_FFFF, 32'h100, 32'h0, 4'hF);
        mem_op("lbu", 1'b0, 32'h103, 32'h0, 5'd11, 1'b1, 2'b00, 1'b1, 0,
               32'h80FF_FFFF, 32'h80FF_FFFF, 32'h100, 32'h0, 4'hF);
        mem_op("lh",  1'b0, 32'h102, 32'h0, 5'd13, 1'b1, 2'b01, 1'b0, 0,
               32'h8001_1234, 32'h8001_1234, 32'h100, 32'h0, 4'hF);
        mem_op("sh",  1'b1, 32'h206, 32'h0000_ABCD, 5'd0, 1'b0, 2'b01, 1'b0, 1,
               32'h0, 32'h0, 32'h204, 32'h0000_ABCD, 4'hF);
`endif

        alu_op(32'hCAFE_0001, 5'd1, 1'b1, 1'b1);

        repeat (3) @(negedge CLK);
        check("wb_queue_drained",  32'(wb_q.size()),  32'd0);
        check("req_queue_drained", 32'(req_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
